gf2_poly_div: RTL and testbench

//   Sequential carry-less (GF(2)[x]) long divider: dividend(x) = q(x)*divisor(x) + r(x).

---
 rtl/gf2_pkg.sv | 19 +
 rtl/gf2_poly_div.sv | 103 ++++++++++
 tb/tb_gf2_poly_div.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2_pkg.sv
// gf2_pkg: shared state encoding and width helpers for the GF(2)[x] divider
package gf2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int DW(input int w);
        return 2 * w - 1;
    endfunction

    function automatic int RW(input int w);
        return w - 1;
    endfunction

endpackage

// File: rtl/gf2_poly_div.sv
// gf2_poly_div: sequential carry-less long divider, one quotient bit per cycle after normalisation
module gf2_poly_div
    import gf2_pkg::*;
#(
    parameter int W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-2:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*W-2:0]   quotient,
    output logic [W-2:0]     remainder,
    output logic             div_by_zero
);

    localparam int DL = DW(W);
    localparam int RL = RW(W);
    localparam int CW = $clog2(2 * W);

    state_t          state, state_n;
    logic [DL-1:0]   r, bd, q;
    logic [CW-1:0]   k, cnt, ptr;
    logic            dz;

    assign ready = (state == IDLE);
    assign busy  = ~ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state: zero divisor skips straight to DONE; DIV ends when the iteration count runs out
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = (divisor == '0) ? DONE : NORM;
            NORM: if (bd[DL-1]) state_n = DIV;
            DIV:  if (cnt == '0) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // datapath: load, normalise the aligned divisor, shift-subtract, then publish results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            bd          <= '0;
            q           <= '0;
            k           <= '0;
            cnt         <= '0;
            ptr         <= '0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    r  <= (divisor == '0) ? '0 : dividend;
                    bd <= {divisor, {RL{1'b0}}};
                    q  <= '0;
                    k  <= '0;
                    dz <= (divisor == '0);
                end
                NORM: if (!bd[DL-1]) begin
                    bd <= bd << 1;
                    k  <= k + 1'b1;
                end else begin
                    cnt <= CW'(W) + k - 1'b1;
                    ptr <= CW'(DL - 1);
                end
                DIV: begin
                    r   <= r[ptr] ? (r ^ bd) : r;
                    q   <= {q[DL-2:0], r[ptr]};
                    bd  <= bd >> 1;
                    ptr <= ptr - 1'b1;
                    cnt <= cnt - 1'b1;
                end
                DONE: begin
                    done        <= 1'b1;
                    quotient    <= q;
                    remainder   <= r[RL-1:0];
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

    // the high part of the partial remainder must be fully cancelled by the time we publish
    a_rem_high_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state == DONE) |-> (r[DL-1:RL] == '0));

endmodule

// File: tb/tb_gf2_poly_div.sv
// tb_gf2_poly_div: directed and exhaustive checks of the W=3 GF(2) divider
module tb_gf2_poly_div;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] dividend = '0;
    logic [2:0] divisor = '0;
    logic       ready, busy, done, div_by_zero;
    logic [4:0] quotient;
    logic [1:0] remainder;

    int checks = 0;
    int failures = 0;

    gf2_poly_div #(.W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] clmul(input logic [4:0] a, input logic [2:0] b);
        logic [6:0] p = '0;
        for (int i = 0; i < 3; i++)
            if (b[i]) p ^= 7'(a) << i;
        return p;
    endfunction

    // start one operation, scramble inputs after acceptance, return edges until done
    task automatic do_op(input logic [4:0] a, input logic [2:0] b, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        lat = 0;
        while (!done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 50) begin
            checks++;
            failures++;
            $display("FAIL done_timeout a=%b b=%b got no done within %0d edges", a, b, lat);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({ready, busy, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 1'b0, 5'b0, 2'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset r/b/d=%b%b%b q=%b r=%b dz=%b want 100 00000 00 0",
                     ready, busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        logic [4:0] va [4] = '{5'b10101, 5'b01111, 5'b10000, 5'b10110};
        logic [2:0] vb [4] = '{3'b111, 3'b011, 3'b011, 3'b001};
        logic [4:0] vq [4] = '{5'b00111, 5'b00101, 5'b01111, 5'b10110};
        logic [1:0] vr [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
        int         vl [4] = '{5, 7, 7, 9};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], lat);
            checks++;
            if (lat !== vl[i]) begin
                failures++;
                $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vl[i]);
            end
            checks++;
            if ({quotient, remainder, div_by_zero} !== {vq[i], vr[i], 1'b0}) begin
                failures++;
                $display("FAIL vec%0d_result q=%b r=%b dz=%b want q=%b r=%b dz=0",
                         i, quotient, remainder, div_by_zero, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat;
        do_op(5'b11011, 3'b000, lat);
        checks++;
        if (lat !== 1 || {quotient, remainder, div_by_zero} !== {5'b0, 2'b0, 1'b1}) begin
            failures++;
            $display("FAIL div_zero lat=%0d q=%b r=%b dz=%b want lat=1 q=0 r=0 dz=1",
                     lat, quotient, remainder, div_by_zero);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (div_by_zero !== 1'b1 || ready !== 1'b1) begin
            failures++;
            $display("FAIL div_zero_hold dz=%b ready=%b want 1 1", div_by_zero, ready);
        end
        do_op(5'b10000, 3'b011, lat);
        checks++;
        if ({quotient, remainder, div_by_zero} !== {5'b01111, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL div_zero_clear q=%b r=%b dz=%b want 01111 01 0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_busy_start;
        int dones = 0;
        @(negedge clk);
        dividend = 5'b10101;
        divisor  = 3'b111;
        start    = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start    = (i < 3);
            dividend = 5'b11111;
            divisor  = 3'b001;
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        start = 1'b0;
        checks++;
        if (dones !== 1 || quotient !== 5'b00111) begin
            failures++;
            $display("FAIL busy_start dones=%0d q=%b want 1 00111", dones, quotient);
        end
    endtask

    task automatic test_mid_reset;
        int dones = 0;
        @(negedge clk);
        dividend = 5'b10110;
        divisor  = 3'b001;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, busy, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 1'b0, 5'b0, 2'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset r/b/d=%b%b%b q=%b r=%b dz=%b want 100 00000 00 0",
                     ready, busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL mid_reset_no_done dones=%0d want 0", dones);
        end
    endtask

    task automatic test_back_to_back;
        int first = -1, second = -1;
        logic [4:0] q1 = '0;
        @(negedge clk);
        dividend = 5'b10101;
        divisor  = 3'b111;
        start    = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done && first < 0) begin
                first    = e;
                q1       = quotient;
                dividend = 5'b01111;
                divisor  = 3'b011;
            end else if (done && second < 0) begin
                second = e;
                start  = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (first !== 5 || q1 !== 5'b00111) begin
            failures++;
            $display("FAIL b2b_first edge=%0d q=%b want 5 00111", first, q1);
        end
        checks++;
        if (second !== 13 || quotient !== 5'b00101) begin
            failures++;
            $display("FAIL b2b_second edge=%0d q=%b want 13 00101", second, quotient);
        end
    endtask

    task automatic test_exhaustive;
        int lat, k, degb;
        for (int b = 1; b < 8; b++) begin
            k    = b[2] ? 0 : (b[1] ? 1 : 2);
            degb = 2 - k;
            for (int a = 0; a < 32; a++) begin
                do_op(5'(a), 3'(b), lat);
                checks++;
                if ((clmul(quotient, 3'(b)) ^ 7'(remainder)) !== 7'(a) || lat !== 3 + 2 * k + 2) begin
                    failures++;
                    $display("FAIL exh_roundtrip a=%b b=%b q=%b r=%b lat=%0d want q*b^r=a lat=%0d",
                             5'(a), 3'(b), quotient, remainder, lat, 3 + 2 * k + 2);
                end
                checks++;
                if ((int'(remainder) >> degb) != 0) begin
                    failures++;
                    $display("FAIL exh_degree a=%b b=%b r=%b want deg r < %0d",
                             5'(a), 3'(b), remainder, degb);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_div_zero;
        test_busy_start;
        test_mid_reset;
        test_back_to_back;
        test_exhaustive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
